// File: rtl/cache_data_array_nway.sv
// N-way set-associative L1 data array with a handshaked read port, a byte-masked write port and a beat-serial refill port.
// Optional per-byte even parity storage and checking is enabled with CACHE_DATA_ARRAY_PARITY_EN.
module cache_data_array_nway #(
  parameter int ID         = 0,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 16,
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_WIDTH = 128,
  localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH,
  localparam int SET_W     = $clog2(NUM_SETS),
  localparam int WAY_W     = $clog2(NUM_WAYS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [SET_W-1:0]        rd_set,
  input  logic [WAY_W-1:0]        rd_way,
  output logic                    rd_resp_valid,
  input  logic                    rd_resp_ready,
  output logic [LINE_WIDTH-1:0]   rd_resp_data,
  input  logic                    wr_en,
  input  logic [SET_W-1:0]        wr_set,
  input  logic [WAY_W-1:0]        wr_way,
  input  logic [LINE_WIDTH-1:0]   wr_data,
  input  logic [LINE_WIDTH/8-1:0] wr_byte_en,
  input  logic                    fill_valid,
  output logic                    fill_ready,
  input  logic [SET_W-1:0]        fill_set,
  input  logic [WAY_W-1:0]        fill_way,
  input  logic [BEAT_WIDTH-1:0]   fill_data,
  output logic                    fill_done,
  output logic                    parity_err
);

  localparam int BYTES  = LINE_WIDTH / 8;
  localparam int ADDR_W = SET_W + WAY_W;
  localparam int DEPTH  = NUM_WAYS * NUM_SETS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (ID < 0 || NUM_WAYS < 2 || NUM_SETS < 2 || (BEAT_WIDTH % 8) != 0 ||
      (LINE_WIDTH % BEAT_WIDTH) != 0) begin : g_param_check
    $error("cache_data_array_nway: illegal parameter set");
  end

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_COLLECT,
    FILL_COMMIT
  } fill_state_e;

  logic [LINE_WIDTH-1:0] mem [DEPTH];

  fill_state_e           fillState_q, fillState_d;
  logic [CNT_W-1:0]      beatCnt_q, beatCnt_d;
  logic [LINE_WIDTH-1:0] fillLine_q;
  logic [SET_W-1:0]      fillSet_q;
  logic [WAY_W-1:0]      fillWay_q;
  logic                  fillCapture;
  logic                  fillCommit;

  logic                  respValid_q;
  logic [LINE_WIDTH-1:0] respData_q;
  logic [LINE_WIDTH-1:0] fwdData;
  logic                  rdAccept;

  logic [ADDR_W-1:0]     rdAddr, wrAddr, fillAddr;

  assign rdAddr   = {rd_way, rd_set};
  assign wrAddr   = {wr_way, wr_set};
  assign fillAddr = {fillWay_q, fillSet_q};

  assign rd_req_ready  = !respValid_q || rd_resp_ready;
  assign rdAccept      = rd_req_valid && rd_req_ready;
  assign rd_resp_valid = respValid_q;
  assign rd_resp_data  = respData_q;

  // Refill FSM: beats are gathered into a line buffer, then committed once the core write port is idle.
  always_comb begin
    fillState_d = fillState_q;
    beatCnt_d   = beatCnt_q;
    fill_ready  = 1'b1;
    fill_done   = 1'b0;
    fillCapture = 1'b0;
    unique case (fillState_q)
      FILL_IDLE: begin
        if (fill_valid) begin
          fillCapture = 1'b1;
          beatCnt_d   = CNT_W'(1);
          fillState_d = (BEATS == 1) ? FILL_COMMIT : FILL_COLLECT;
        end
      end
      FILL_COLLECT: begin
        if (fill_valid) begin
          if (beatCnt_q == CNT_W'(BEATS - 1)) begin
            beatCnt_d   = '0;
            fillState_d = FILL_COMMIT;
          end else begin
            beatCnt_d = beatCnt_q + CNT_W'(1);
          end
        end
      end
      FILL_COMMIT: begin
        fill_ready = 1'b0;
        if (!wr_en) begin
          fill_done   = 1'b1;
          beatCnt_d   = '0;
          fillState_d = FILL_IDLE;
        end
      end
      default: fillState_d = FILL_IDLE;
    endcase
  end

  assign fillCommit = fill_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fillState_q <= FILL_IDLE;
      beatCnt_q   <= '0;
      respValid_q <= 1'b0;
    end else begin
      fillState_q <= fillState_d;
      beatCnt_q   <= beatCnt_d;
      if (rdAccept) begin
        respValid_q <= 1'b1;
      end else if (rd_resp_ready) begin
        respValid_q <= 1'b0;
      end
    end
  end

  // Datapath registers carry no reset; their contents only matter once the FSM or valid flag says so.
  always_ff @(posedge clock) begin
    if (fill_valid && fill_ready) begin
      fillLine_q[beatCnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= fill_data;
    end
    if (fillCapture) begin
      fillSet_q <= fill_set;
      fillWay_q <= fill_way;
    end
    if (rdAccept) begin
      respData_q <= fwdData;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_byte_en[b]) begin
          mem[wrAddr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end else if (fillCommit) begin
      mem[fillAddr] <= fillLine_q;
    end
  end

  // Write-first forwarding so a read colliding with a same-cycle write sees the new bytes.
  always_comb begin
    fwdData = mem[rdAddr];
    if (fillCommit && (fillAddr == rdAddr)) begin
      fwdData = fillLine_q;
    end else if (wr_en && (wrAddr == rdAddr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_byte_en[b]) begin
          fwdData[b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

`ifdef CACHE_DATA_ARRAY_PARITY_EN
  function automatic logic [BYTES-1:0] lineParity(input logic [LINE_WIDTH-1:0] line);
    logic [BYTES-1:0] par;
    par = '0;
    for (int b = 0; b < BYTES; b++) begin
      par[b] = ^line[b*8 +: 8];
    end
    return par;
  endfunction

  logic [BYTES-1:0] parMem [DEPTH];
  logic [BYTES-1:0] respPar_q;
  logic [BYTES-1:0] fwdPar;
  logic [BYTES-1:0] wrPar;
  logic [BYTES-1:0] fillPar;

  assign wrPar   = lineParity(wr_data);
  assign fillPar = lineParity(fillLine_q);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_byte_en[b]) begin
          parMem[wrAddr][b] <= wrPar[b];
        end
      end
    end else if (fillCommit) begin
      parMem[fillAddr] <= fillPar;
    end
    if (rdAccept) begin
      respPar_q <= fwdPar;
    end
  end

  always_comb begin
    fwdPar = parMem[rdAddr];
    if (fillCommit && (fillAddr == rdAddr)) begin
      fwdPar = fillPar;
    end else if (wr_en && (wrAddr == rdAddr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_byte_en[b]) begin
          fwdPar[b] = wrPar[b];
        end
      end
    end
  end

  assign parity_err = respValid_q && (lineParity(respData_q) != respPar_q);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_data_array_nway.sv
// Directed testbench for cache_data_array_nway: reset, read/write, collisions, stalls, refill and parity.
// Define CACHE_DATA_ARRAY_PARITY_EN to also exercise parity error detection.
module tb_cache_data_array_nway;

  logic         clock;
  logic         reset;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [3:0]   rd_set;
  logic [1:0]   rd_way;
  logic         rd_resp_valid;
  logic         rd_resp_ready;
  logic [511:0] rd_resp_data;
  logic         wr_en;
  logic [3:0]   wr_set;
  logic [1:0]   wr_way;
  logic [511:0] wr_data;
  logic [63:0]  wr_byte_en;
  logic         fill_valid;
  logic         fill_ready;
  logic [3:0]   fill_set;
  logic [1:0]   fill_way;
  logic [127:0] fill_data;
  logic         fill_done;
  logic         parity_err;

  int checks = 0;
  int errors = 0;

  logic [511:0] fillLineA;

  cache_data_array_nway #(
    .ID(0), .NUM_WAYS(4), .NUM_SETS(16), .LINE_WIDTH(512), .BEAT_WIDTH(128)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_set(rd_set), .rd_way(rd_way),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
    .wr_data(wr_data), .wr_byte_en(wr_byte_en),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_set(fill_set), .fill_way(fill_way), .fill_data(fill_data),
    .fill_done(fill_done), .parity_err(parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic writeLine(input logic [3:0] s, input logic [1:0] w, input logic [511:0] d);
    wr_en = 1'b1; wr_set = s; wr_way = w; wr_data = d; wr_byte_en = '1;
    tick();
    wr_en = 1'b0; wr_byte_en = '0;
  endtask

  task automatic issueRead(input logic [3:0] s, input logic [1:0] w);
    rd_req_valid = 1'b1; rd_set = s; rd_way = w;
    tick();
    rd_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (rd_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", rd_resp_valid); end
    checks++;
    if (fill_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fill_done got %b want 0", fill_done); end
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_err got %b want 0", parity_err); end
    checks++;
    if (fill_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_fill_ready got %b want 1", fill_ready); end
    checks++;
    if (rd_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_rd_req_ready got %b want 1", rd_req_ready); end
    reset = 1'b0;
    tick();
    rd_resp_ready = 1'b0;
    issueRead(4'd0, 2'd0);
    checks++;
    if (rd_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL pending_before_reset got %b want 1", rd_resp_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if (rd_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_drops_resp got %b want 0", rd_resp_valid); end
    @(negedge clock);
    reset = 1'b0;
    rd_resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    writeLine(4'd3, 2'd2, {64{8'hA5}});
    rd_req_valid = 1'b1; rd_set = 4'd3; rd_way = 2'd2;
    #1;
    checks++;
    if (rd_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_rd_valid_before got %b want 0", rd_resp_valid); end
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (rd_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wr_rd_valid_latency got %b want 1", rd_resp_valid); end
    checks++;
    if (rd_resp_data !== {64{8'hA5}}) begin errors++; $display("[TB] FAIL wr_rd_data got %h want %h", rd_resp_data, {64{8'hA5}}); end
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_rd_parity got %b want 0", parity_err); end
    tick();
    checks++;
    if (rd_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_rd_valid_drop got %b want 0", rd_resp_valid); end
  endtask

  task automatic test_collision();
    logic [511:0] expLine;
    expLine = {504'h0, 8'h7E};
    writeLine(4'd5, 2'd1, '0);
    wr_en = 1'b1; wr_set = 4'd5; wr_way = 2'd1;
    wr_data = {{63{8'hFF}}, 8'h7E}; wr_byte_en = 64'h1;
    rd_req_valid = 1'b1; rd_set = 4'd5; rd_way = 2'd1;
    tick();
    wr_en = 1'b0; wr_byte_en = '0; rd_req_valid = 1'b0;
    checks++;
    if (rd_resp_data !== expLine) begin errors++; $display("[TB] FAIL collide_fwd got %h want %h", rd_resp_data, expLine); end
    tick();
    issueRead(4'd5, 2'd1);
    checks++;
    if (rd_resp_data !== expLine) begin errors++; $display("[TB] FAIL collide_ram got %h want %h", rd_resp_data, expLine); end
    tick();
  endtask

  task automatic test_stall();
    writeLine(4'd2, 2'd0, {64{8'h11}});
    rd_resp_ready = 1'b0;
    issueRead(4'd2, 2'd0);
    wr_en = 1'b1; wr_set = 4'd2; wr_way = 2'd0; wr_data = {64{8'h22}}; wr_byte_en = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rd_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_ready[%0d] got %b want 0", i, rd_req_ready); end
      checks++;
      if (rd_resp_valid !== 1'b1 || rd_resp_data !== {64{8'h11}}) begin
        errors++; $display("[TB] FAIL stall_hold[%0d] valid %b data %h want 1 %h", i, rd_resp_valid, rd_resp_data, {64{8'h11}});
      end
      tick();
      wr_en = 1'b0; wr_byte_en = '0;
    end
    rd_resp_ready = 1'b1;
    rd_req_valid = 1'b1; rd_set = 4'd2; rd_way = 2'd0;
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready got %b want 1", rd_req_ready); end
    tick();
    checks++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== {64{8'h22}}) begin
      errors++; $display("[TB] FAIL stall_new_data valid %b data %h want 1 %h", rd_resp_valid, rd_resp_data, {64{8'h22}});
    end
    rd_set = 4'd3; rd_way = 2'd2;
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== {64{8'hA5}}) begin
      errors++; $display("[TB] FAIL back_to_back valid %b data %h want 1 %h", rd_resp_valid, rd_resp_data, {64{8'hA5}});
    end
    tick();
    checks++;
    if (rd_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL back_to_back_drain got %b want 0", rd_resp_valid); end
  endtask

  task automatic test_fill_priority();
    logic [127:0] beats [4];
    beats[0] = {32{4'h1}}; beats[1] = {32{4'h2}}; beats[2] = {32{4'h3}}; beats[3] = {32{4'h4}};
    fillLineA = {beats[3], beats[2], beats[1], beats[0]};
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_data = beats[k];
      fill_set = (k == 0) ? 4'd7 : 4'd0;
      fill_way = (k == 0) ? 2'd3 : 2'd0;
      #1;
      checks++;
      if (fill_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready_beat[%0d] got %b want 1", k, fill_ready); end
      tick();
    end
    fill_valid = 1'b0;
    wr_en = 1'b1; wr_set = 4'd1; wr_way = 2'd1; wr_data = '0; wr_byte_en = '1;
    #1;
    checks++;
    if (fill_ready !== 1'b0 || fill_done !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_blocked ready %b done %b want 0 0", fill_ready, fill_done);
    end
    tick();
    wr_en = 1'b0; wr_byte_en = '0;
    rd_req_valid = 1'b1; rd_set = 4'd7; rd_way = 2'd3;
    #1;
    checks++;
    if (fill_done !== 1'b1) begin errors++; $display("[TB] FAIL fill_done_pulse got %b want 1", fill_done); end
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (fill_done !== 1'b0 || fill_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL fill_after_commit done %b ready %b want 0 1", fill_done, fill_ready);
    end
    checks++;
    if (rd_resp_data !== fillLineA) begin errors++; $display("[TB] FAIL fill_fwd got %h want %h", rd_resp_data, fillLineA); end
    tick();
    issueRead(4'd7, 2'd3);
    checks++;
    if (rd_resp_data !== fillLineA) begin errors++; $display("[TB] FAIL fill_ram got %h want %h", rd_resp_data, fillLineA); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [511:0] expLine;
    logic [127:0] beats [4];
    int doneSeen;
    fill_set = 4'd7; fill_way = 2'd3;
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1'b1; fill_data = {32{4'(k + 5)}};
      tick();
    end
    fill_valid = 1'b0;
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fill_done) doneSeen++;
      @(negedge clock);
    end
    reset = 1'b0;
    checks++;
    if (doneSeen != 0 || fill_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_fill done_seen %0d ready %b want 0 1", doneSeen, fill_ready);
    end
    tick();
    issueRead(4'd7, 2'd3);
    checks++;
    if (rd_resp_data !== fillLineA) begin errors++; $display("[TB] FAIL reset_fill_line got %h want %h", rd_resp_data, fillLineA); end
    tick();
    beats[0] = {32{4'h9}}; beats[1] = {32{4'hA}}; beats[2] = {32{4'hB}}; beats[3] = {32{4'hC}};
    expLine = {beats[3], beats[2], beats[1], beats[0]};
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_data = beats[k];
      fill_set = (k == 0) ? 4'd4 : 4'd15;
      fill_way = (k == 0) ? 2'd1 : 2'd2;
      tick();
    end
    fill_valid = 1'b0;
    #1;
    checks++;
    if (fill_done !== 1'b1) begin errors++; $display("[TB] FAIL refill_done got %b want 1", fill_done); end
    tick();
    issueRead(4'd4, 2'd1);
    checks++;
    if (rd_resp_data !== expLine) begin errors++; $display("[TB] FAIL refill_line got %h want %h", rd_resp_data, expLine); end
    tick();
  endtask

  task automatic test_parity();
    writeLine(4'd6, 2'd0, {64{8'h3C}});
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    dut.mem[6][0] = ~dut.mem[6][0];
    rd_resp_ready = 1'b0;
    issueRead(4'd6, 2'd0);
    checks++;
    if (rd_resp_valid !== 1'b1 || parity_err !== 1'b1) begin
      errors++; $display("[TB] FAIL parity_detect valid %b err %b want 1 1", rd_resp_valid, parity_err);
    end
    tick();
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_hold got %b want 1", parity_err); end
    rd_resp_ready = 1'b1;
    tick();
`else
    issueRead(4'd6, 2'd0);
    checks++;
    if (rd_resp_valid !== 1'b1 || parity_err !== 1'b0) begin
      errors++; $display("[TB] FAIL parity_tied valid %b err %b want 1 0", rd_resp_valid, parity_err);
    end
    tick();
`endif
  endtask

  initial begin
    reset = 1'b1;
    rd_req_valid = 1'b0; rd_set = '0; rd_way = '0; rd_resp_ready = 1'b1;
    wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_data = '0; wr_byte_en = '0;
    fill_valid = 1'b0; fill_set = '0; fill_way = '0; fill_data = '0;
    fillLineA = '0;
    test_reset();
    test_write_read();
    test_collision();
    test_stall();
    test_fill_priority();
    test_reset_mid_fill();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_data_array_nway.md
Name: cache_data_array_nway

Overview:
- N-way set-associative L1 data array: NUM_WAYS × NUM_SETS lines of LINE_WIDTH bits in block RAM.
- Serves one core read port with valid/ready request and response handshakes, plus one byte-enabled core write port.
- Has a beat-serial refill port that assembles a line from BEAT_WIDTH beats and commits it in a single RAM write.
- Sits between the cache controller and the memory-side refill path.

Parameters:
- ID, 0, core index used in debug prints.
- NUM_WAYS, 4, ways per set; power of two, ≥2.
- NUM_SETS, 16, sets; power of two, ≥2.
- LINE_WIDTH, 512, line width in bits; multiple of BEAT_WIDTH.
- BEAT_WIDTH, 128, refill beat width; multiple of 8.
- Derived, not overridable: BEATS=LINE_WIDTH/BEAT_WIDTH, SET_W=$clog2(NUM_SETS), WAY_W=$clog2(NUM_WAYS).

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when valid&&ready.
- rd_set  in  SET_W  read set index.
- rd_way  in  WAY_W  read way.
- rd_resp_valid  out  1  response valid.
- rd_resp_ready  in  1  consumer accepts response.
- rd_resp_data  out  LINE_WIDTH  response line.
- wr_en  in  1  core write, single cycle, no handshake.
- wr_set  in  SET_W  write set index.
- wr_way  in  WAY_W  write way.
- wr_data  in  LINE_WIDTH  write data.
- wr_byte_en  in  LINE_WIDTH/8  per-byte enable.
- fill_valid  in  1  refill beat valid.
- fill_ready  out  1  refill beat accepted.
- fill_set  in  SET_W  refill set; sampled on beat 0 only.
- fill_way  in  WAY_W  refill way; sampled on beat 0 only.
- fill_data  in  BEAT_WIDTH  refill beat; beat k lands at bits [k*BEAT_WIDTH +: BEAT_WIDTH].
- fill_done  out  1  one-cycle pulse in the cycle the refill line is written to RAM.
- parity_err  out  1  parity mismatch on the current response.

Behaviour:
- RAM contents are not reset. Reset values: rd_resp_valid=0, fill_done=0, parity_err=0, fill FSM=IDLE, beat counter=0. rd_resp_data is undefined while rd_resp_valid=0.
- Read handshake:
  - rd_req_ready = !rd_resp_valid || rd_resp_ready.
  - A request accepted in cycle T gives rd_resp_valid=1 in T+1.
  - The response holds stable (data and parity_err) until rd_resp_ready.
  - Back-to-back accepts sustain 1 read/cycle.
  - The RAM output register updates only on accept.
- Read/write collision, write-first: an accepted read in cycle T whose set/way equals a write in T (core write or fill commit) returns the new bytes.
  - For a core write: enabled bytes from wr_data, others from RAM.
  - For a fill commit: the full fill line.
  - A write to a line whose response is already pending does not alter the pending response.
- Core write: applied in the same cycle, byte-masked. wr_byte_en=0 is a no-op.
- Fill FSM states: IDLE, COLLECT, COMMIT.
  - IDLE: fill_ready=1. On fill_valid, capture fill_set, fill_way and beat 0; cnt=1; go to COLLECT, or to COMMIT if BEATS==1.
  - COLLECT: fill_ready=1. Each handshake stores beat cnt; when cnt==BEATS-1 go to COMMIT, else cnt++.
  - COMMIT: fill_ready=0. Full-line write to RAM when wr_en=0; in that cycle fill_done=1 and next state is IDLE. If wr_en=1, wait; the core write has priority and the fill retries next cycle.
- A core write to the line being filled, before commit, is overwritten by the commit (last writer wins; the controller avoids this).
- Reset mid-fill: partial beats are discarded, no RAM write occurs, FSM returns to IDLE. Reset with a response pending drops the response.

Optional Feature:
- Macro: CACHE_DATA_ARRAY_PARITY_EN.
- Defined:
  - Stores one even-parity bit per byte, LINE_WIDTH/8 extra bits per line, written under the same byte enables.
  - The response recomputes parity on the (forwarded) data.
  - parity_err=1 alongside rd_resp_valid when any byte mismatches; held while stalled.
- Undefined: no parity storage; parity_err is tied to 0.

Test Plan:
- Reset, write (set 3, way 2, all bytes 0xA5), then read (3,2) → rd_resp_valid exactly 1 cycle after accept, data = 512'hA5…A5, parity_err=0.
- Same-cycle read and write to (5,1): old line = 0, wr_byte_en=64'h1 with byte 0 = 0x7E → response byte 0 = 0x7E, all other bytes 0.
- Read accepted, rd_resp_ready held 0 for 3 cycles, write to the same line meanwhile → rd_req_ready=0 and data unchanged for 3 cycles; the next read returns the new data.
- Refill of 4 beats 0x1…, 0x2…, 0x3…, 0x4… into (7,3) with wr_en=1 in the commit cycle → commit delayed 1 cycle, fill_done pulses once, read (7,3) = {beat3, beat2, beat1, beat0}.
- Assert reset after refill beat 2 → no fill_done, line (7,3) unchanged, the next refill starts capturing at beat 0.
- With CACHE_DATA_ARRAY_PARITY_EN defined, force one stored data bit flipped → parity_err=1 with rd_resp_valid; without the macro, parity_err stays 0.
